// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-stage valid/ready register pipeline with bubble
// collapsing, flush and an occupancy count.
// Optional feature macro: PIPE_STAGE_PERF_EN adds the stall_cnt/xfer_cnt
// performance counters (saturating, cleared only by reset).
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               out_data,
  input  logic                           out_ready,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]                    stall_cnt,
  output logic [31:0]                    xfer_cnt
`endif
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH-1:0] r;

  // Readiness ripples from the output end back to stage 0.
  always_comb begin
    r = '0;
    r[DEPTH-1] = !v_q[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      r[i] = !v_q[i] | r[i+1];
    end
  end

  assign in_ready = r[0];

  // Per-stage next state: flush clears, ready stages load (bubbles load as
  // zero payload), stalled stages hold.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             up_v;
      logic [WIDTH-1:0] up_d;
      if (gi == 0) begin : g_src_in
        assign up_v = in_valid;
        assign up_d = in_data;
      end else begin : g_src_prev
        assign up_v = v_q[gi-1];
        assign up_d = d_q[gi-1];
      end
      assign v_d[gi] = flush ? 1'b0 : (r[gi] ? up_v : v_q[gi]);
      assign d_d[gi] = flush ? '0
                     : (r[gi] ? (up_v ? up_d : '0) : d_q[gi]);
    end
  endgenerate

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
    end else begin
      v_q <= v_d;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

  // Occupancy is the population count of the registered valid bits.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(v_q[i]);
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] xfer_cnt_q,  xfer_cnt_d;

  // Saturating counters; flush deliberately has no effect on them.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (out_valid && out_ready && (xfer_cnt_q != 32'hFFFF_FFFF))
      xfer_cnt_d = xfer_cnt_q + 32'd1;
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign xfer_cnt  = xfer_cnt_q;
`endif

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, legal range 1..256.
REQ-002 Parameter DEPTH, default 2: number of register stages, legal range 1..8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 flush  input  1  active-high; discards every stage's content on the next edge.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 in_ready  output  1  chain accepts in_data this cycle (combinational).
REQ-009 out_valid  output  1  last stage holds a valid payload.
REQ-010 out_data  output  WIDTH  last-stage payload; all zeros when out_valid=0.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 occupancy  output  clog2(DEPTH+1)  number of currently valid stages.

Function
REQ-013 Each stage i (0..DEPTH-1) SHALL hold a valid bit v[i] and payload d[i]; stage 0 is the input side, stage DEPTH-1 drives out_valid/out_data.
REQ-014 Stage readiness SHALL be r[DEPTH-1] = !v[DEPTH-1] | out_ready and r[i] = !v[i] | r[i+1]; in_ready SHALL equal r[0].
REQ-015 When r[i]=1, stage i SHALL load from its upstream source (stage i-1, or in_valid/in_data for i=0) on the edge; when r[i]=0, it SHALL hold.
REQ-016 A stage loading an invalid upstream (bubble) SHALL set v[i]=0 and d[i]=0; invalid stages SHALL always hold zero payload.
REQ-017 Bubbles SHALL collapse: a valid item advances into an empty downstream stage even while out_ready=0.
REQ-018 Minimum latency SHALL be DEPTH cycles from an accepted input to out_valid; sustained throughput SHALL be one item per cycle with out_ready held high.
REQ-019 Items SHALL leave in acceptance order; no item is dropped or duplicated except by flush or reset.
REQ-020 flush=1 SHALL clear every v[i] and d[i] to 0 on the edge, overriding loads and holds; in_data offered in that cycle SHALL be discarded; in_ready is still computed per REQ-014.
REQ-021 occupancy SHALL equal the population count of v[] as registered, updated every edge.
REQ-022 Simultaneous accept at stage 0 and emit at stage DEPTH-1 SHALL leave occupancy unchanged.

Reset
REQ-023 While reset=0 at an edge, all v[i]=0, all d[i]=0, and occupancy=0; out_valid=0 and out_data=0 follow.
REQ-024 Reset SHALL take priority over flush and all handshakes; an in-flight transfer at reset is lost.
REQ-025 After reset deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-026 Macro PIPE_STAGE_PERF_EN defined: add outputs stall_cnt[31:0] and xfer_cnt[31:0].
REQ-027 With the macro, stall_cnt increments each cycle with out_valid=1 and out_ready=0; xfer_cnt increments each cycle with out_valid=1 and out_ready=1.
REQ-028 With the macro, both counters saturate at 0xFFFFFFFF, clear only on reset (not on flush), and are unaffected by flush.
REQ-029 Without the macro, neither port nor counter logic exists; all other behaviour is identical.

Verification (WIDTH=32, DEPTH=2)
REQ-030 Reset deasserted, out_ready=1, push 0xA5A5A5A5 at cycle 0 -> out_valid=1, out_data=0xA5A5A5A5 at cycle 2; occupancy 1 from cycle 1 through cycle 2, then 0 once emitted.
REQ-031 out_ready=0, push 0x1, 0x2, 0x3 back-to-back -> 0x1 and 0x2 are accepted, occupancy=2, in_ready=0 on the third cycle; then out_ready=1 -> outputs 0x1, 0x2 in order, then 0x3.
REQ-032 Chain full (0x10, 0x20), assert flush with in_valid=1 and in_data=0x30 -> next cycle occupancy=0, out_valid=0, out_data=0; 0x30 is never emitted.
REQ-033 out_ready=0, v=[0,1], push 0x7 -> 0x7 is accepted into stage 0 while stage 1 holds; occupancy=2.
REQ-034 Full chain, reset=0 for one cycle concurrent with flush=1 and out_ready=1 -> all cleared; with PIPE_STAGE_PERF_EN, stall_cnt=0 and xfer_cnt=0 afterwards.
REQ-035 PIPE_STAGE_PERF_EN defined: 5 cycles of out_valid=1/out_ready=0 followed by 3 transfers -> stall_cnt=5, xfer_cnt=3; a subsequent flush leaves both values unchanged.
